bootram_bus_bridge: RTL and testbench
=====================================

// Module: bootram_bus_bridge
// PURPOSE
//  Native PicoRV32 memory-bus target that fronts the four 2Kx8 Gowin SP byte lanes
//  (bootram_2kx8_0..3) forming the 8 KB boot RAM. Decodes word address, fans out
//  byte-strobed writes, gathers the 32-bit read word, and generates the mem_ready handshake.
//  Sits between the SoC bus interconnect (upstream) and the byte-lane RAM macros (downstream).
// PARAMETERS
//  AW          11   word-address width per lane (2^AW words; lanes are 2Kx8)
//  HOLD_RDATA  1    1: mem_s_rdata holds last read word between accesses; 0: zero when !ready
// PORTS
//  clk          in   1    system clock, all logic rising-edge
//  reset        in   1    asynchronous, active-high reset
//  mem_s_valid  in   1    bus request valid; held high until mem_s_ready
//  mem_s_sel    in   1    address decode hit for boot RAM window
//  mem_s_addr   in   32   byte address; bits [AW+1:2] used, others ignored (alias)
//  mem_s_wdata  in   32   write data
//  mem_s_wstrb  in   4    byte strobes; 4'b0000 = read
//  mem_s_ready  out  1    one-cycle completion pulse
//  mem_s_rdata  out  32   read data, valid when mem_s_ready && read
//  ram_ad       out  AW   word address to all lanes
//  ram_ce       out  1    lane clock enable
//  ram_oce      out  1    lane output-register enable (tied 1; bypass read mode)
//  ram_wre      out  4    per-lane write enable, lane i = byte i
//  ram_din      out  32   {lane3,lane2,lane1,lane0} write bytes
//  ram_dout     in   32   {lane3,lane2,lane1,lane0} read bytes
//  wp_lock      in   1    write-protect request (only with BOOTRAM_WP_EN)
//  wp_err       out  1    write-blocked pulse (only with BOOTRAM_WP_EN)
// BEHAVIOUR
//  Reset: state=IDLE, mem_s_ready=0, mem_s_rdata=0, ram_ce=0, ram_wre=0, rdata_q=0, wp_err=0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: on mem_s_valid&&mem_s_sel latch addr/wdata/wstrb; go ACCESS. Else stay; ram_ce=0.
//   ACCESS: ram_ce=1, ram_ad=addr_q[AW+1:2], ram_din=wdata_q, ram_wre=wstrb_q (per bit).
//           Lanes sample on this edge; go RESP.
//   RESP: mem_s_ready=1 (registered); read: rdata_q<=ram_dout, mem_s_rdata=ram_dout; go IDLE.
//  Latency: valid sampled at edge N -> ready high during cycle N+2, exactly one cycle.
//  Write partial strobes: only strobed lanes get wre; unstrobed bytes unchanged.
//  Write completion: mem_s_rdata = rdata_q (HOLD_RDATA=1) or 0.
//  Back-to-back: valid still high in IDLE the cycle after RESP starts a new access;
//   throughput one access per 3 cycles.
//  valid without sel: ignored, no RAM activity, no ready.
//  Address wrap: addr bits above AW+1 ignored; 0x2000 aliases 0x0000.
//  Reset mid-access: FSM to IDLE immediately, ready/wre/ce drop asynchronously;
//   an in-flight write may or may not have committed.
//  valid deasserted mid-transaction (protocol violation): transaction still completes.
// CONFIGURATION
//  BOOTRAM_WP_EN defined: ports wp_lock/wp_err exist. If wp_lock=1 when an access is latched
//   and wstrb!=0, ram_wre stays 0, ready still pulses normally, wp_err pulses with ready.
//   Reads unaffected.
//  Undefined: ports absent, every write honoured per wstrb.
// TESTING
//  1 reset release, idle 10 cycles -> ready=0, ram_ce=0, ram_wre=0, rdata=0.
//  2 write 0xDEADBEEF @0x0010 wstrb=F, then read @0x0010
//    -> ram_wre=4'hF once, read ready at N+2, rdata=0xDEADBEEF.
//  3 write 0x000000AA @0x0010 wstrb=4'b0001, read
//    -> rdata=0xDEADBEAA; only ram_wre[0] asserted.
//  4 read @0x2010 -> ram_ad=0x004, rdata=0xDEADBEAA (alias);
//    valid with sel=0 -> no ce, no ready for 8 cycles.
//  5 back-to-back reads @0x0,0x4,0x8 with valid held
//    -> ready pulses 3 cycles apart, data matches preload image.
//  6 BOOTRAM_WP_EN, wp_lock=1, write 0x12345678 @0x0
//    -> ready=1, wp_err=1, ram_wre=0, readback unchanged;
//    assert reset in ACCESS -> ready never pulses, state IDLE.

Source files
------------

// File: rtl/bootram_bus_bridge.sv
// PicoRV32 native-bus target for the 8 KB boot RAM built from four 2Kx8 byte lanes.
// Optional write protect: define BOOTRAM_WP_EN to add wp_lock/wp_err.
module bootram_bus_bridge #(
    parameter int AW         = 11,
    parameter bit HOLD_RDATA = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_s_valid,
    input  logic          mem_s_sel,
    input  logic [31:0]   mem_s_addr,
    input  logic [31:0]   mem_s_wdata,
    input  logic [3:0]    mem_s_wstrb,
    output logic          mem_s_ready,
    output logic [31:0]   mem_s_rdata,
    output logic [AW-1:0] ram_ad,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic [3:0]    ram_wre,
    output logic [31:0]   ram_din,
`ifdef BOOTRAM_WP_EN
    input  logic          wp_lock,
    output logic          wp_err,
`endif
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [3:0]    wre_q;
    logic          is_rd_q;
    logic          ce_q;
    logic          ready_q;
    logic          wp_blk_q;
    logic          wp_err_q;
    logic          wp_blk_d;
    logic          unused_addr;

    assign unused_addr = ^{mem_s_addr[31:AW+2], mem_s_addr[1:0]};

`ifdef BOOTRAM_WP_EN
    assign wp_blk_d = wp_lock && (mem_s_wstrb != 4'h0);
    assign wp_err   = wp_err_q;
`else
    assign wp_blk_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wre_q    <= '0;
            is_rd_q  <= 1'b0;
            ce_q     <= 1'b0;
            ready_q  <= 1'b0;
            wp_blk_q <= 1'b0;
            wp_err_q <= 1'b0;
        end else begin
            ce_q     <= 1'b0;
            wre_q    <= '0;
            ready_q  <= 1'b0;
            wp_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_s_valid && mem_s_sel) begin
                        addr_q   <= mem_s_addr[AW+1:2];
                        wdata_q  <= mem_s_wdata;
                        is_rd_q  <= (mem_s_wstrb == 4'h0);
                        wp_blk_q <= wp_blk_d;
                        ce_q     <= 1'b1;
                        wre_q    <= wp_blk_d ? 4'h0 : mem_s_wstrb;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready_q  <= 1'b1;
                    wp_err_q <= wp_blk_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (is_rd_q) begin
                        rdata_q <= ram_dout;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_s_ready = ready_q;
    assign ram_ce      = ce_q;
    assign ram_oce     = 1'b1;
    assign ram_wre     = wre_q;
    assign ram_ad      = addr_q;
    assign ram_din     = wdata_q;

    // Lanes run in bypass mode, so the read word is on ram_dout during RESP.
    always_comb begin
        mem_s_rdata = '0;
        if (ready_q && is_rd_q) begin
            mem_s_rdata = ram_dout;
        end else if (HOLD_RDATA) begin
            mem_s_rdata = rdata_q;
        end
    end

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// Scoreboard bench for bootram_bus_bridge with a behavioural lane model.
// Build with BOOTRAM_WP_EN defined to exercise write protect.
module tb_bootram_bus_bridge;

    localparam int AW = 11;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_s_valid = 1'b0;
    logic          mem_s_sel = 1'b1;
    logic [31:0]   mem_s_addr = '0;
    logic [31:0]   mem_s_wdata = '0;
    logic [3:0]    mem_s_wstrb = '0;
    logic          mem_s_ready;
    logic [31:0]   mem_s_rdata;
    logic [AW-1:0] ram_ad;
    logic          ram_ce;
    logic          ram_oce;
    logic [3:0]    ram_wre;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;
`ifdef BOOTRAM_WP_EN
    logic          wp_lock = 1'b0;
    logic          wp_err;
`endif

    bootram_bus_bridge #(.AW(AW), .HOLD_RDATA(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .mem_s_valid(mem_s_valid),
        .mem_s_sel(mem_s_sel),
        .mem_s_addr(mem_s_addr),
        .mem_s_wdata(mem_s_wdata),
        .mem_s_wstrb(mem_s_wstrb),
        .mem_s_ready(mem_s_ready),
        .mem_s_rdata(mem_s_rdata),
        .ram_ad(ram_ad),
        .ram_ce(ram_ce),
        .ram_oce(ram_oce),
        .ram_wre(ram_wre),
        .ram_din(ram_din),
`ifdef BOOTRAM_WP_EN
        .wp_lock(wp_lock),
        .wp_err(wp_err),
`endif
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        wperr;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] ad;
        logic [3:0]    wre;
    } ce_t;

    rsp_t        rspq[$];
    ce_t         ceq[$];
    logic [31:0] ref_mem [NW];
    logic [31:0] last_rd = '0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] img(int w);
        return 32'(w) * 32'h9E37_79B1 ^ 32'h5A5A_1234;
    endfunction

    // Gowin SP lane model: synchronous, output updated on read cycles.
    logic [7:0] lane [4][NW];
    bit         loaded = 1'b0;
    always @(posedge clk) begin
        logic [31:0] t;
        if (!loaded) begin
            for (int w = 0; w < NW; w++) begin
                t = img(w);
                for (int b = 0; b < 4; b++) lane[b][w] <= t[8*b +: 8];
            end
            loaded <= 1'b1;
        end else if (ram_ce) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wre[b]) lane[b][ram_ad] <= ram_din[8*b +: 8];
                else ram_dout[8*b +: 8] <= lane[b][ram_ad];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_s_ready && n < 8);
        if (!mem_s_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit first);
        rsp_t r;
        ce_t  c;
        logic blk;
        int   idx;
        blk = 1'b0;
`ifdef BOOTRAM_WP_EN
        blk = wp_lock && (s != 4'h0);
`endif
        idx = int'(a[AW+1:2]);
        c.ad  = a[AW+1:2];
        c.wre = blk ? 4'h0 : s;
        if (s == 4'h0) begin
            r.rdata = ref_mem[idx];
            last_rd = ref_mem[idx];
        end else begin
            r.rdata = last_rd;
            if (!blk)
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
        r.wperr = blk;
        r.cyc   = cyc + (first ? 2 : 3);
        ceq.push_back(c);
        rspq.push_back(r);
        mem_s_valid = 1'b1;
        mem_s_sel   = 1'b1;
        mem_s_addr  = a;
        mem_s_wdata = d;
        mem_s_wstrb = s;
        wait_ready();
    endtask

    task automatic idle();
        mem_s_valid = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT shows lane or bus activity.
    initial begin
        ce_t  c;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!reset && loaded) begin
                if (ram_ce) begin
                    if (ceq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_ce actual=1 required=0");
                    end else begin
                        c = ceq.pop_front();
                        check("ram_ad", 32'(ram_ad), 32'(c.ad));
                        check("ram_wre", 32'(ram_wre), 32'(c.wre));
                    end
                end
                if (mem_s_ready) begin
                    if (rspq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_ready actual=1 required=0");
                    end else begin
                        r = rspq.pop_front();
                        check("rdata", mem_s_rdata, r.rdata);
                        check("latency", 32'(cyc), 32'(r.cyc));
`ifdef BOOTRAM_WP_EN
                        check("wp_err", 32'(wp_err), 32'(r.wperr));
`endif
                    end
                end
            end
        end
    end

    initial begin
        ce_t c;
        int  seen;
        int  len;
        logic [3:0] s;
        for (int w = 0; w < NW; w++) ref_mem[w] = img(w);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_ready", 32'(mem_s_ready), 32'd0);
        check("rst_ce", 32'(ram_ce), 32'd0);
        check("rst_wre", 32'(ram_wre), 32'd0);
        check("rst_rdata", mem_s_rdata, 32'd0);

        access(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1); idle();
        access(32'h0000_0010, 32'h0, 4'h0, 1'b1); idle();
        access(32'h0000_0010, 32'h0000_00AA, 4'b0001, 1'b1); idle();
        access(32'h0000_0010, 32'h0, 4'h0, 1'b1); idle();
        check("partial_merge", ref_mem[4], 32'hDEAD_BEAA);
        access(32'h0000_2010, 32'h0, 4'h0, 1'b1); idle();

        mem_s_valid = 1'b1;
        mem_s_sel   = 1'b0;
        mem_s_addr  = 32'h10;
        mem_s_wstrb = 4'hF;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_s_ready || ram_ce) seen++;
        end
        check("nosel_activity", 32'(seen), 32'd0);
        mem_s_sel = 1'b1;
        idle();

        access(32'h0, 32'h0, 4'h0, 1'b1);
        access(32'h4, 32'h0, 4'h0, 1'b0);
        access(32'h8, 32'h0, 4'h0, 1'b0);
        idle();

`ifdef BOOTRAM_WP_EN
        wp_lock = 1'b1;
        access(32'h0, 32'h1234_5678, 4'hF, 1'b1); idle();
        wp_lock = 1'b0;
        access(32'h0, 32'h0, 4'h0, 1'b1); idle();
`endif

        c.ad  = 11'h7FF;
        c.wre = 4'hF;
        ceq.push_back(c);
        mem_s_valid = 1'b1;
        mem_s_addr  = 32'h0000_1FFC;
        mem_s_wdata = 32'h0BAD_0BAD;
        mem_s_wstrb = 4'hF;
        @(negedge clk);
        #1;
        reset = 1'b1;
        mem_s_valid = 1'b0;
        #1;
        check("midrst_ready", 32'(mem_s_ready), 32'd0);
        check("midrst_ce", 32'(ram_ce), 32'd0);
        check("midrst_wre", 32'(ram_wre), 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        @(negedge clk);
        check("post_rst_rdata", mem_s_rdata, 32'd0);
        access(32'h0000_1FFC, 32'hCAFE_F00D, 4'hF, 1'b1); idle();
        access(32'h0000_1FFC, 32'h0, 4'h0, 1'b1); idle();

        for (int i = 0; i < 40; i++) begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
`ifdef BOOTRAM_WP_EN
                wp_lock = ($urandom_range(0, 3) == 0);
`endif
                s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                access($urandom & 32'hFFFF_FFFC, $urandom, s, j == 0);
            end
            idle();
        end

        repeat (5) @(negedge clk);
        check("rsp_drained", 32'(rspq.size()), 32'd0);
        check("ce_drained", 32'(ceq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
